spram_arbiter: RTL and testbench
================================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter IDLE_LIMIT, default 64, meaning consecutive request-free cycles in ACTIVE before standby entry (range 1..65535).
REQ-002 SHALL have parameter WAKE_CYC, default 2, meaning cycles spent in WAKE before the first grant (range 1..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock, which also clocks the SPRAM.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have, per requester x in {a,b}, the following inputs: x_req 1 bit (request, held until acknowledged), x_we 1 bit (1 = write), x_ad 14 bits (word address), x_di 16 bits (write data), x_mask 4 bits (nibble write enables).
REQ-007 SHALL have, per requester x, the following outputs: x_ack 1 bit (access accepted this cycle), x_rvalid 1 bit (read data valid), x_do 16 bits (read data).
REQ-008 SHALL have SPRAM-side outputs ram_ad 14 bits, ram_di 16 bits, ram_maskwe 4 bits, ram_we 1 bit, ram_cs 1 bit and ram_stdby 1 bit, plus input ram_do 16 bits.
REQ-009 SHALL have output busy, 1 bit: high in any state other than ACTIVE-with-no-request.

Function
REQ-010 SHALL implement three states: ACTIVE, STBY and WAKE.
REQ-011 In ACTIVE, SHALL grant at most one requester per cycle; the grant and the RAM command are combinational from the requests and the state.
REQ-012 Arbitration SHALL be round-robin: a 1-bit last-grant register selects priority, and the requester not granted last wins a contention; with a single requester, that requester is granted.
REQ-013 On a grant, SHALL assert x_ack for the granted requester only and drive ram_cs=1, ram_we=x_we, ram_ad=x_ad, ram_di=x_di, ram_maskwe=(x_we ? x_mask : 4'b0000).
REQ-014 When there is no grant, SHALL drive ram_cs=0, ram_we=0, ram_maskwe=0; ram_ad and ram_di are don't-care.
REQ-015 Read latency SHALL be 1: for a read granted in cycle N, x_rvalid=1 in cycle N+1 and x_do=ram_do in that cycle.
REQ-016 SHALL route ram_do to both x_do outputs; only the x_rvalid strobe selects the owner.
REQ-017 A write SHALL commit at the clock edge ending its grant cycle and SHALL produce no rvalid.
REQ-018 Back-to-back grants SHALL be allowed, including a read followed by a write from the other requester, with no bubble cycle.
REQ-019 In ACTIVE, a 16-bit idle counter SHALL increment on each cycle with no request and clear on any request.
REQ-020 When the idle counter reaches IDLE_LIMIT, the FSM SHALL go to STBY.
REQ-021 STBY SHALL be entered only when no read is pending, so that an rvalid is never lost.
REQ-022 In STBY, SHALL hold ram_stdby=1 and ram_cs=0, and issue no acks.
REQ-023 In STBY, any x_req SHALL move the FSM to WAKE on the next edge.
REQ-024 In WAKE, SHALL drive ram_stdby=0 and ram_cs=0 and count WAKE_CYC cycles, then enter ACTIVE; the first grant is possible in the first ACTIVE cycle.
REQ-025 A request deasserted during WAKE SHALL still complete the WAKE→ACTIVE transition; no grant results.
REQ-026 x_req inputs SHALL be ignored in STBY and WAKE; requesters keep x_req held, and no request is lost.
REQ-027 ram_stdby SHALL be 0 in ACTIVE and WAKE and 1 only in STBY.

Reset
REQ-028 rst=1 at an edge SHALL set state=ACTIVE, the idle counter to 0, the wake counter to 0, last-grant=b (so a has priority first), and both rvalid registers to 0.
REQ-029 During rst=1, all acks, ram_cs, ram_we, ram_maskwe and ram_stdby SHALL be 0.
REQ-030 Reset asserted mid-read SHALL suppress the pending rvalid; reset asserted in STBY or WAKE SHALL return the FSM to ACTIVE with ram_stdby=0 after the edge.

Verification
REQ-031 Bench SHALL cover: a-only write 0x1234 to 0x0010 with mask 4'b1111, then a read of 0x0010 → a_ack on both accesses, a_rvalid one cycle after the read ack, a_do=0x1234.
REQ-032 Bench SHALL cover: a and b requesting continuously after reset → ack order a,b,a,b; no cycle with both acks; no idle gap.
REQ-033 Bench SHALL cover: masked write of 0xABCD with mask 4'b0010 over 0x0000 → a read returns 0x00C0.
REQ-034 Bench SHALL cover: IDLE_LIMIT=4 with no requests → ram_stdby rises after 4 idle cycles; b_req then → WAKE for WAKE_CYC cycles with ram_cs=0, then b_ack in the first ACTIVE cycle.
REQ-035 Bench SHALL cover: a read granted, then rst in the next cycle → a_rvalid stays 0, and the FSM is ACTIVE with all outputs at reset values.
REQ-036 Bench SHALL cover: a request arriving in the same cycle the idle counter hits IDLE_LIMIT → the counter clears, no STBY entry, and the request is granted immediately.

Source files
------------

// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if -- bundle of the two requester ports and the SPRAM port.
//   a_* / b_*  : per-requester request (req, we, ad, di, mask) and
//                response (ack, rvalid, do)
//   ram_*      : single-port RAM command (ad, di, maskwe, we, cs, stdby)
//                and registered read data (ram_do)
//   busy       : arbiter is doing something other than idling in ACTIVE
// Modports: slave = arbiter side, master = requesters + RAM side.
interface spram_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [13:0] a_ad;
  logic [15:0] a_di;
  logic [3:0]  a_mask;
  logic        a_ack;
  logic        a_rvalid;
  logic [15:0] a_do;

  logic        b_req;
  logic        b_we;
  logic [13:0] b_ad;
  logic [15:0] b_di;
  logic [3:0]  b_mask;
  logic        b_ack;
  logic        b_rvalid;
  logic [15:0] b_do;

  logic [13:0] ram_ad;
  logic [15:0] ram_di;
  logic [3:0]  ram_maskwe;
  logic        ram_we;
  logic        ram_cs;
  logic        ram_stdby;
  logic [15:0] ram_do;

  logic        busy;

  modport slave (
    input  a_req, a_we, a_ad, a_di, a_mask,
    input  b_req, b_we, b_ad, b_di, b_mask,
    input  ram_do,
    output a_ack, a_rvalid, a_do,
    output b_ack, b_rvalid, b_do,
    output ram_ad, ram_di, ram_maskwe, ram_we, ram_cs, ram_stdby,
    output busy
  );

  modport master (
    output a_req, a_we, a_ad, a_di, a_mask,
    output b_req, b_we, b_ad, b_di, b_mask,
    output ram_do,
    input  a_ack, a_rvalid, a_do,
    input  b_ack, b_rvalid, b_do,
    input  ram_ad, ram_di, ram_maskwe, ram_we, ram_cs, ram_stdby,
    input  busy
  );
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter -- two-requester round-robin arbiter in front of one SPRAM,
// with automatic standby after IDLE_LIMIT request-free cycles and a
// WAKE_CYC-cycle wake-up before the first grant.
//   clk  : single clock (also clocks the SPRAM)
//   rst  : synchronous, active-high reset
//   bus  : spram_arbiter_if.slave (requesters a/b, SPRAM port, busy)
// Grants and the RAM command are combinational from requests and state;
// read data arrives one cycle after the grant, tagged by x_rvalid.
module spram_arbiter #(
  parameter int unsigned IDLE_LIMIT = 64,
  parameter int unsigned WAKE_CYC   = 2
) (
  input  logic           clk,
  input  logic           rst,
  spram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_STBY,
    ST_WAKE
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(IDLE_LIMIT - 1);
  localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] idle_q, idle_d;
  logic [3:0]  wake_q, wake_d;
  logic        last_q, last_d;     // 1 = b granted last
  logic        a_rv_q, a_rv_d;
  logic        b_rv_q, b_rv_d;

  logic        any_req;
  logic        gnt_a, gnt_b;
  logic        stdby;

  assign any_req = bus.a_req | bus.b_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
      last_q  <= 1'b1;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      last_q  <= last_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    stdby   = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        // Contention goes to whoever was not granted last.
        gnt_a = bus.a_req & (~bus.b_req | last_q);
        gnt_b = bus.b_req & (~bus.a_req | ~last_q);
        if (any_req) begin
          idle_d = '0;
        end else begin
          if (idle_q != '1) idle_d = idle_q + 16'd1;
          // Comparing the pre-increment count lets a request arriving in
          // the limit cycle still win; the pending-read guard may defer
          // entry, hence >= rather than ==.
          if (idle_q >= IDLE_LAST && !a_rv_q && !b_rv_q) begin
            state_d = ST_STBY;
          end
        end
      end
      ST_STBY: begin
        stdby  = 1'b1;
        idle_d = '0;
        wake_d = '0;
        if (any_req) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        idle_d = '0;
        wake_d = wake_q + 4'd1;
        if (wake_q >= WAKE_LAST) begin
          state_d = ST_ACTIVE;
          wake_d  = '0;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      stdby = 1'b0;
    end
  end

  assign last_d = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_q);
  assign a_rv_d = gnt_a & ~bus.a_we;
  assign b_rv_d = gnt_b & ~bus.b_we;

  assign bus.a_ack      = gnt_a;
  assign bus.b_ack      = gnt_b;
  // Masking with rst drops a read whose data would land in a reset cycle.
  assign bus.a_rvalid   = a_rv_q & ~rst;
  assign bus.b_rvalid   = b_rv_q & ~rst;
  assign bus.a_do       = bus.ram_do;
  assign bus.b_do       = bus.ram_do;

  assign bus.ram_cs     = gnt_a | gnt_b;
  assign bus.ram_we     = (gnt_a & bus.a_we) | (gnt_b & bus.b_we);
  assign bus.ram_ad     = gnt_b ? bus.b_ad : bus.a_ad;
  assign bus.ram_di     = gnt_b ? bus.b_di : bus.a_di;
  assign bus.ram_maskwe = (gnt_a & bus.a_we) ? bus.a_mask :
                          (gnt_b & bus.b_we) ? bus.b_mask : '0;
  assign bus.ram_stdby  = stdby;

  assign bus.busy       = !(state_q == ST_ACTIVE && !any_req);

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter -- directed-vector bench for spram_arbiter with a small
// behavioural SPRAM (registered read, nibble write enables).
module tb_spram_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  spram_arbiter_if bus ();

  spram_arbiter #(
    .IDLE_LIMIT (4),
    .WAKE_CYC   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  always @(posedge clk) begin
    if (bus.ram_cs && !bus.ram_stdby) begin
      if (bus.ram_we) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.ram_maskwe[k]) mem[bus.ram_ad][4*k +: 4] <= bus.ram_di[4*k +: 4];
        end
      end
      bus.ram_do <= mem[bus.ram_ad];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [13:0] ad,
                         input logic [15:0] di, input logic [3:0] mask);
    bus.a_req = req; bus.a_we = we; bus.a_ad = ad; bus.a_di = di; bus.a_mask = mask;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [13:0] ad,
                         input logic [15:0] di, input logic [3:0] mask);
    bus.b_req = req; bus.b_we = we; bus.b_ad = ad; bus.b_di = di; bus.b_mask = mask;
  endtask

  task automatic idle_reqs();
    drive_a(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
    drive_b(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
  endtask

  // Two reset cycles; outputs checked while rst is high.
  task automatic do_reset();
    rst = 1'b1;
    idle_reqs();
    @(negedge clk);
    check("rst_a_ack",  32'(bus.a_ack), 32'h0);
    check("rst_b_ack",  32'(bus.b_ack), 32'h0);
    check("rst_cs",     32'(bus.ram_cs), 32'h0);
    check("rst_we",     32'(bus.ram_we), 32'h0);
    check("rst_maskwe", 32'(bus.ram_maskwe), 32'h0);
    check("rst_stdby",  32'(bus.ram_stdby), 32'h0);
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.ram_do = '0;
    rst = 1'b1;
    idle_reqs();

    // a-only write then read back
    do_reset();
    drive_a(1'b1, 1'b1, 14'h0010, 16'h1234, 4'hF);
    @(negedge clk);
    check("wr_a_ack",  32'(bus.a_ack), 32'h1);
    check("wr_b_ack",  32'(bus.b_ack), 32'h0);
    check("wr_cs",     32'(bus.ram_cs), 32'h1);
    check("wr_we",     32'(bus.ram_we), 32'h1);
    check("wr_maskwe", 32'(bus.ram_maskwe), 32'hF);
    check("wr_ad",     32'(bus.ram_ad), 32'h0010);
    check("wr_di",     32'(bus.ram_di), 32'h1234);
    next_cyc();
    drive_a(1'b1, 1'b0, 14'h0010, 16'h0, 4'hF);
    @(negedge clk);
    check("rd_a_ack",     32'(bus.a_ack), 32'h1);
    check("rd_we",        32'(bus.ram_we), 32'h0);
    check("rd_maskwe",    32'(bus.ram_maskwe), 32'h0);
    check("wr_no_rvalid", 32'(bus.a_rvalid), 32'h0);
    next_cyc();
    idle_reqs();
    @(negedge clk);
    check("rd_a_rvalid", 32'(bus.a_rvalid), 32'h1);
    check("rd_b_rvalid", 32'(bus.b_rvalid), 32'h0);
    check("rd_a_do",     32'(bus.a_do), 32'h1234);
    check("rd_idle_cs",  32'(bus.ram_cs), 32'h0);
    next_cyc();
    @(negedge clk);
    check("rd_rvalid_drop", 32'(bus.a_rvalid), 32'h0);
    next_cyc();

    // Round-robin with both requesting continuously: a,b,a,b,...
    do_reset();
    drive_a(1'b1, 1'b0, 14'h0100, 16'h0, 4'h0);
    drive_b(1'b1, 1'b0, 14'h0200, 16'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_a_ack", 32'(bus.a_ack), 32'((i % 2) == 0));
      check("rr_b_ack", 32'(bus.b_ack), 32'((i % 2) == 1));
      check("rr_cs",    32'(bus.ram_cs), 32'h1);
      if (i > 0) check("rr_a_rvalid", 32'(bus.a_rvalid), 32'(((i - 1) % 2) == 0));
      next_cyc();
    end
    idle_reqs();

    // Masked write over zero, read, then a write from b with no bubble
    do_reset();
    drive_b(1'b1, 1'b1, 14'h0000, 16'h0000, 4'hF);
    @(negedge clk);
    check("mz_b_ack", 32'(bus.b_ack), 32'h1);
    next_cyc();
    drive_b(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
    drive_a(1'b1, 1'b1, 14'h0000, 16'hABCD, 4'b0010);
    @(negedge clk);
    check("mw_a_ack",  32'(bus.a_ack), 32'h1);
    check("mw_maskwe", 32'(bus.ram_maskwe), 32'h2);
    next_cyc();
    drive_a(1'b1, 1'b0, 14'h0000, 16'h0, 4'h0);
    @(negedge clk);
    check("mr_a_ack", 32'(bus.a_ack), 32'h1);
    next_cyc();
    drive_a(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
    drive_b(1'b1, 1'b1, 14'h0005, 16'h5555, 4'hF);
    @(negedge clk);
    check("mr_a_rvalid", 32'(bus.a_rvalid), 32'h1);
    check("mr_a_do",     32'(bus.a_do), 32'h00C0);
    check("b2b_b_ack",   32'(bus.b_ack), 32'h1);
    check("b2b_we",      32'(bus.ram_we), 32'h1);
    next_cyc();
    idle_reqs();
    @(negedge clk);
    check("b2b_no_rvalid", 32'(bus.b_rvalid), 32'h0);
    next_cyc();

    // Standby after 4 idle cycles, wake on b_req, grant after 2 WAKE cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_stdby", 32'(bus.ram_stdby), 32'h0);
      check("idle_busy",  32'(bus.busy), 32'h0);
      next_cyc();
    end
    @(negedge clk);
    check("sb_stdby", 32'(bus.ram_stdby), 32'h1);
    check("sb_busy",  32'(bus.busy), 32'h1);
    next_cyc();
    drive_b(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0);
    @(negedge clk);
    check("sb_req_stdby", 32'(bus.ram_stdby), 32'h1);
    check("sb_req_ack",   32'(bus.b_ack), 32'h0);
    check("sb_req_cs",    32'(bus.ram_cs), 32'h0);
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wk_stdby", 32'(bus.ram_stdby), 32'h0);
      check("wk_cs",    32'(bus.ram_cs), 32'h0);
      check("wk_ack",   32'(bus.b_ack), 32'h0);
      next_cyc();
    end
    @(negedge clk);
    check("wk_done_b_ack", 32'(bus.b_ack), 32'h1);
    check("wk_done_cs",    32'(bus.ram_cs), 32'h1);
    next_cyc();
    idle_reqs();

    // Reset one cycle after a read grant suppresses the rvalid
    do_reset();
    drive_a(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0);
    @(negedge clk);
    check("rr_rst_ack", 32'(bus.a_ack), 32'h1);
    next_cyc();
    rst = 1'b1;
    idle_reqs();
    @(negedge clk);
    check("rr_rst_rvalid", 32'(bus.a_rvalid), 32'h0);
    check("rr_rst_cs",     32'(bus.ram_cs), 32'h0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rr_post_rvalid", 32'(bus.a_rvalid), 32'h0);
    check("rr_post_busy",   32'(bus.busy), 32'h0);
    check("rr_post_stdby",  32'(bus.ram_stdby), 32'h0);
    next_cyc();
    // Reset while in standby returns to ACTIVE
    for (int i = 0; i < 4; i++) next_cyc();
    @(negedge clk);
    check("rs_sb_stdby", 32'(bus.ram_stdby), 32'h1);
    do_reset();
    @(negedge clk);
    check("rs_after_stdby", 32'(bus.ram_stdby), 32'h0);
    check("rs_after_busy",  32'(bus.busy), 32'h0);
    next_cyc();

    // Request in the cycle the idle count hits the limit: granted, no standby
    do_reset();
    for (int i = 0; i < 3; i++) next_cyc();
    drive_a(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0);
    @(negedge clk);
    check("lim_a_ack", 32'(bus.a_ack), 32'h1);
    check("lim_stdby", 32'(bus.ram_stdby), 32'h0);
    next_cyc();
    idle_reqs();
    @(negedge clk);
    check("lim_stdby2", 32'(bus.ram_stdby), 32'h0);
    check("lim_rvalid", 32'(bus.a_rvalid), 32'h1);
    check("lim_do",     32'(bus.a_do), 32'h1234);
    next_cyc();
    next_cyc();
    next_cyc();
    @(negedge clk);
    check("lim_cleared", 32'(bus.ram_stdby), 32'h0);
    next_cyc();
    @(negedge clk);
    check("lim_then_sb", 32'(bus.ram_stdby), 32'h1);
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
